// File: rtl/ds_dac_sequencer.sv
// Sample pacer for the delta_sigma DAC: buffers samples in a small FIFO, delivers one
// per sample tick and ramps ds_in to/from mid-scale so enabling or disabling never pops.
module ds_dac_sequencer #(
  parameter int IN_BITS   = 32,
  parameter int CLK_HZ    = 12_000_000,
  parameter int SAMPLE_HZ = 5_000,
  parameter int DEPTH     = 4,
  parameter int RAMP_STEP = 2 ** (IN_BITS - 6)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [IN_BITS-1:0]       s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     ds_ena,
  output logic [IN_BITS-1:0]       ds_in,
  output logic                     busy,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int TICK_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int CW       = $clog2(TICK_DIV);
  localparam int AW       = $clog2(DEPTH);
  localparam int NW       = AW + 1;

  // One extra bit so ramp arithmetic can saturate instead of wrapping.
  localparam logic [IN_BITS:0] MID  = (IN_BITS + 1)'(1) << (IN_BITS - 1);
  localparam logic [IN_BITS:0] STEP = (IN_BITS + 1)'(RAMP_STEP);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DOWN = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IN_BITS-1:0] ds_in_q, ds_in_d;
  logic               under_q, under_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]      count_q, count_d;
  logic [IN_BITS-1:0] mem [DEPTH];

  logic               tick, active, full, push, pop, flush;
  logic [IN_BITS:0]   sum_up;

  assign tick    = (cnt_q == CW'(TICK_DIV - 1));
  assign active  = (state_q == S_UP) || (state_q == S_RUN);
  assign full    = (count_q == NW'(DEPTH));
  assign s_ready = active && !full;
  assign push    = s_valid && s_ready;
  assign sum_up  = {1'b0, ds_in_q} + STEP;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ds_in_d = ds_in_q;
    under_d = under_q;
    pop     = 1'b0;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_UP;
          under_d = 1'b0;
        end
      end
      S_UP: begin
        if (tick) begin
          ds_in_d = (sum_up >= MID) ? MID[IN_BITS-1:0] : sum_up[IN_BITS-1:0];
          if (sum_up >= MID) state_d = S_RUN;
        end
        if (stop) state_d = S_DOWN;
      end
      S_RUN: begin
        if (tick) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            ds_in_d = mem[rd_ptr_q];
          end else begin
            under_d = 1'b1;
          end
        end
        if (stop) state_d = S_DOWN;
      end
      default: begin
        if (ds_in_q == '0) begin
          state_d = S_IDLE;
        end else if (tick) begin
          ds_in_d = ({1'b0, ds_in_q} > STEP) ? ds_in_q - STEP[IN_BITS-1:0] : '0;
        end
      end
    endcase
  end

  // The FIFO is emptied on the way into RAMP_DOWN and held empty while idle or ramping down.
  assign flush = (state_d == S_DOWN) || (state_q == S_IDLE) || (state_q == S_DOWN);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + NW'(push) - NW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ds_in_q  <= '0;
      under_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ds_in_q  <= ds_in_d;
      under_q  <= under_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: sample storage has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= s_data;
  end

  assign ds_ena     = (state_q != S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign ds_in      = ds_in_q;
  assign underrun   = under_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_ds_dac_sequencer.sv
// Self-checking bench for ds_dac_sequencer: directed scenarios plus random traffic,
// all compared cycle by cycle against a queue-based behavioural model.
module tb_ds_dac_sequencer;

  localparam int IN_BITS  = 8;
  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 10;
  localparam int STEP     = 32;
  localparam int MID      = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, stop = 1'b0, s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready, ds_ena, busy, underrun;
  logic [7:0] ds_in;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;

  typedef enum {M_IDLE, M_UP, M_RUN, M_DOWN} mode_t;
  mode_t m_state = M_IDLE;
  int    m_ds    = 0;
  bit    m_under = 1'b0;
  bit    m_tick  = 1'b0;
  int    cyc     = 0;
  int    q[$];

  ds_dac_sequencer #(
    .IN_BITS(IN_BITS), .CLK_HZ(1000), .SAMPLE_HZ(100), .DEPTH(DEPTH), .RAMP_STEP(STEP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .ds_ena(ds_ena), .ds_in(ds_in), .busy(busy), .underrun(underrun),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_ds = 0; m_under = 1'b0; m_tick = 1'b0; cyc = 0;
    q.delete();
  endtask

  // Behaviour over one clock edge, from the current model state and the driven inputs.
  task automatic model_step(input bit st, input bit sp, input bit v, input int d);
    bit    ready, tick;
    mode_t nxt;
    int    nds;
    ready = (m_state == M_UP || m_state == M_RUN) && q.size() < DEPTH;
    tick  = (cyc % TICK_DIV) == TICK_DIV - 1;
    cyc++;
    nxt = m_state;
    nds = m_ds;
    case (m_state)
      M_IDLE: if (st && !sp) begin nxt = M_UP; m_under = 1'b0; end
      M_UP: begin
        if (tick) begin
          nds = (m_ds + STEP > MID) ? MID : m_ds + STEP;
          if (nds == MID) nxt = M_RUN;
        end
        if (sp) nxt = M_DOWN;
      end
      M_RUN: begin
        if (tick) begin
          if (q.size() > 0) nds = q.pop_front();
          else m_under = 1'b1;
        end
        if (sp) nxt = M_DOWN;
      end
      M_DOWN: begin
        if (m_ds == 0) nxt = M_IDLE;
        else if (tick) nds = (m_ds > STEP) ? m_ds - STEP : 0;
      end
    endcase
    if (v && ready) q.push_back(d & 255);
    if (nxt == M_DOWN || m_state == M_IDLE || m_state == M_DOWN) q.delete();
    m_state = nxt;
    m_ds    = nds;
    m_tick  = tick;
  endtask

  task automatic compare_all();
    check("ds_ena", ds_ena, m_state != M_IDLE);
    check("busy", busy, m_state != M_IDLE);
    check("ds_in", ds_in, m_ds);
    check("underrun", underrun, m_under);
    check("fifo_count", fifo_count, q.size());
    check("s_ready", s_ready, (m_state == M_UP || m_state == M_RUN) && q.size() < DEPTH);
  endtask

  task automatic cycle(input bit st, input bit sp, input bit v, input int d);
    @(negedge clk);
    start = st; stop = sp; s_valid = v; s_data = 8'(d);
    model_step(st, sp, v, d);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic run_to_tick(input bit v, input int d);
    for (int i = 0; i < TICK_DIV + 2; i++) begin
      cycle(1'b0, 1'b0, v, d);
      if (m_tick) return;
    end
    check("tick_timeout", 0, 1);
  endtask

  // Called just after a posedge: asserts reset between edges and releases it likewise.
  task automatic async_reset();
    #2;
    start = 1'b0; stop = 1'b0; s_valid = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_ds_ena", ds_ena, 0);
    check("rst_ds_in", ds_in, 0);
    check("rst_underrun", underrun, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo", fifo_count, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ds_ena", ds_ena, 0);
    check("reset_ds_in", ds_in, 0);
    check("reset_busy", busy, 0);
    check("reset_underrun", underrun, 0);
    check("reset_fifo", fifo_count, 0);
    check("reset_s_ready", s_ready, 0);
    #2 rst = 1'b1;

    // Soft-start ramp to mid-scale.
    cycle(1'b1, 1'b0, 1'b0, 0);
    check("t1_ena", ds_ena, 1);
    for (int k = 1; k <= 4; k++) begin
      run_to_tick(1'b0, 0);
      check("t1_ramp", ds_in, STEP * k);
    end
    check("t1_busy", busy, 1);

    // Fill the FIFO, drain one sample per tick, then underrun.
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b0, 1'b1, 16 * i);
    check("t2_full", fifo_count, 4);
    check("t2_ready", s_ready, 0);
    for (int i = 1; i <= 4; i++) begin
      run_to_tick(1'b0, 0);
      check("t2_sample", ds_in, 16 * i);
    end
    run_to_tick(1'b0, 0);
    check("t2_hold", ds_in, 8'h40);
    check("t2_underrun", underrun, 1);

    // Push offered while full, including on the popping tick, is refused.
    cycle(1'b0, 1'b0, 1'b1, 8'h45);
    cycle(1'b0, 1'b0, 1'b1, 8'h50);
    cycle(1'b0, 1'b0, 1'b1, 8'h60);
    cycle(1'b0, 1'b0, 1'b1, 8'h70);
    run_to_tick(1'b1, 8'h99);
    check("t3_count", fifo_count, 3);
    check("t3_ds_in", ds_in, 8'h45);
    run_to_tick(1'b0, 0);
    check("t4_ds_in", ds_in, 8'h50);
    check("t4_count", fifo_count, 2);

    // Stop from RUN: flush and ramp down.
    cycle(1'b0, 1'b1, 1'b0, 0);
    check("t4_flush", fifo_count, 0);
    run_to_tick(1'b0, 0); check("t4_down1", ds_in, 8'h30);
    run_to_tick(1'b0, 0); check("t4_down2", ds_in, 8'h10);
    run_to_tick(1'b0, 0); check("t4_down3", ds_in, 8'h00);
    check("t4_still_ena", ds_ena, 1);
    cycle(1'b0, 1'b0, 1'b0, 0);
    check("t4_idle_ena", ds_ena, 0);
    check("t4_idle_busy", busy, 0);
    check("t4_idle_fifo", fifo_count, 0);

    // Stop during the ramp-up, then simultaneous start/stop in IDLE.
    cycle(1'b1, 1'b0, 1'b0, 0);
    run_to_tick(1'b0, 0);
    run_to_tick(1'b0, 0);
    check("t5_ds_in", ds_in, 64);
    cycle(1'b0, 1'b1, 1'b0, 0);
    run_to_tick(1'b0, 0); check("t5_down1", ds_in, 32);
    run_to_tick(1'b0, 0); check("t5_down2", ds_in, 0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    check("t5_idle", busy, 0);
    cycle(1'b1, 1'b1, 1'b0, 0);
    check("t5_both", busy, 0);
    cycle(1'b0, 1'b0, 1'b0, 0);
    check("t5_both_ena", ds_ena, 0);

    // Asynchronous reset mid-RUN with underrun set.
    cycle(1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 5; k++) run_to_tick(1'b0, 0);
    check("t6_underrun", underrun, 1);
    check("t6_ds_in", ds_in, MID);
    async_reset();
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 1'b1, i);
    check("t6_stays_idle", busy, 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 29) == 0, $urandom_range(0, 79) == 0,
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)));
      if (i == 2000) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
